// File: rtl/crc_scheduler_pkg.sv
// Shared POLI types: word width, requester limit and the CRC scheduler state encoding.
package POLI_types_pkg;

  localparam int WORD_SIZE    = 32;
  localparam int CRC_NREQ_MAX = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } crc_sched_state_t;

endpackage

// File: rtl/crc_scheduler_if.sv
// Connection between the scheduler (master) and the polymorphic CRC generator (slave).
interface crc_generator_if;
  import POLI_types_pkg::*;

  logic [WORD_SIZE-1:0] crc_data_in;
  logic                 crc_reset;
  logic                 crc_start;
  logic [WORD_SIZE-1:0] crc_orient;
  logic [WORD_SIZE-1:0] crc_data_out;
  logic                 crc_ready;

  modport master (
    output crc_data_in, crc_reset, crc_start, crc_orient,
    input  crc_data_out, crc_ready
  );

  modport slave (
    input  crc_data_in, crc_reset, crc_start, crc_orient,
    output crc_data_out, crc_ready
  );

endinterface

// File: rtl/crc_scheduler_rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  always_comb begin
    logic [IW:0] k;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      // one extra bit so ptr+i cannot overflow before the modulo fold
      k = {1'b0, ptr} + (IW+1)'(i);
      if (k >= (IW+1)'(NREQ)) k = k - (IW+1)'(NREQ);
      if (!found && req[k[IW-1:0]]) begin
        found                = 1'b1;
        grant[k[IW-1:0]]     = 1'b1;
        grant_idx            = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/crc_scheduler.sv
// Shares one CRC generator among NREQ requesters: round-robin per message, word-by-word
// start/ready streaming, one-cycle response strobe carrying the final CRC.
module crc_scheduler
  import POLI_types_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WORD_SIZE-1:0] req_data,
  input  logic [NREQ-1:0]           req_last,
  input  logic [NREQ*WORD_SIZE-1:0] req_orient,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           resp_valid,
  output logic [WORD_SIZE-1:0]      resp_crc,
  crc_generator_if.master           gen
);

  localparam int IW = $clog2(NREQ);

  crc_sched_state_t     state;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        rr_ptr;
  logic                 last;
  logic                 first_wait;
  logic [NREQ-1:0]      grant;
  logic [IW-1:0]        grant_idx;
  logic                 issue_now;
  logic [WORD_SIZE-1:0] data_arr   [NREQ];
  logic [WORD_SIZE-1:0] orient_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i]   = req_data[i*WORD_SIZE +: WORD_SIZE];
    assign orient_arr[i] = req_orient[i*WORD_SIZE +: WORD_SIZE];
  end

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A word is issued straight out of CLEAR/WAIT when the owner already has one ready,
  // so LOAD is only occupied while the owner is stalled.
  always_comb begin
    issue_now = 1'b0;
    case (state)
      CLEAR, LOAD: issue_now = req_valid[owner];
      WAIT:        issue_now = !first_wait && gen.crc_ready && !last && req_valid[owner];
      default:     issue_now = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= IDLE;
      owner           <= '0;
      rr_ptr          <= '0;
      last            <= 1'b0;
      first_wait      <= 1'b0;
      req_ready       <= '0;
      resp_valid      <= '0;
      resp_crc        <= '0;
      gen.crc_data_in <= '0;
      gen.crc_reset   <= 1'b0;
      gen.crc_start   <= 1'b0;
      gen.crc_orient  <= '0;
    end else begin
      req_ready       <= '0;
      resp_valid      <= '0;
      gen.crc_data_in <= '0;
      gen.crc_reset   <= 1'b0;
      gen.crc_start   <= 1'b0;
      first_wait      <= 1'b0;

      case (state)
        IDLE: begin
          if (|grant) begin
            owner          <= grant_idx;
            gen.crc_orient <= orient_arr[grant_idx];
            gen.crc_reset  <= 1'b1;
            state          <= CLEAR;
          end
        end
        CLEAR, LOAD: begin
          state <= LOAD;
        end
        WAIT: begin
          if (!first_wait && gen.crc_ready) begin
            if (last) begin
              resp_valid[owner] <= 1'b1;
              resp_crc          <= gen.crc_data_out;
              state             <= DONE;
            end else begin
              state <= LOAD;
            end
          end
        end
        DONE: begin
          rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (issue_now) begin
        gen.crc_data_in  <= data_arr[owner];
        gen.crc_start    <= 1'b1;
        req_ready[owner] <= 1'b1;
        last             <= req_last[owner];
        first_wait       <= 1'b1;
        state            <= WAIT;
      end
    end
  end

endmodule

// File: tb/tb_crc_scheduler.sv
// Directed bench for crc_scheduler with a behavioural generator and requester models.
module tb_crc_scheduler;
  import POLI_types_pkg::*;

  localparam int NREQ = 4;
  // generator output is acc ^ K so that the single-word case yields 0xDEADBEEF
  localparam logic [31:0] K = 32'hC858F520;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [NREQ-1:0]    req_valid, req_last, req_ready, resp_valid;
  logic [NREQ*32-1:0] req_data, req_orient;
  logic [31:0]        resp_crc;

  crc_generator_if gen ();

  crc_scheduler #(.NREQ(NREQ)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_orient (req_orient),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_crc   (resp_crc),
    .gen        (gen)
  );

  // generator model: rotate-xor accumulator, g_busy busy cycles after each start
  int          g_busy = 0;
  int          busy;
  logic        gready;
  logic [31:0] acc;
  assign gen.crc_ready    = gready;
  assign gen.crc_data_out = acc ^ K;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc    <= '0;
      busy   <= 0;
      gready <= 1'b1;
    end else if (gen.crc_reset) begin
      acc <= '0;
    end else if (gen.crc_start) begin
      acc <= {acc[30:0], acc[31]} ^ gen.crc_data_in ^ gen.crc_orient;
      if (g_busy > 0) begin
        busy   <= g_busy;
        gready <= 1'b0;
      end
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) gready <= 1'b1;
    end
  end

  // requester models
  logic [31:0] msg [NREQ][3];
  int          len [NREQ];
  int          pos [NREQ];
  bit          active [NREQ];
  bit          hold [NREQ];
  logic [31:0] orient_r [NREQ];

  // monitor state
  int          cyc = 0;
  int          n_reset, n_start, n_resp, n_overlap, n_multi;
  int          t_reset, t_start0, t_resp;
  int          n_ready [NREQ];
  logic [31:0] d_start0, o_start0;
  int          t_starts [$];
  logic [3:0]  resp_q [$];
  logic [31:0] crc_q [$];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int unsigned req;
    int unsigned nw;
    logic [31:0] w0, w1, w2, orient;
    int unsigned g;
    logic [31:0] exp_crc;
  } vec_t;
  vec_t vt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = active[i] && !hold[i];
      req_data[i*32 +: 32] = active[i] ? msg[i][pos[i]] : 32'h0;
      req_last[i]          = active[i] && (pos[i] == len[i] - 1);
      req_orient[i*32 +: 32] = orient_r[i];
    end
  endtask

  task automatic clear_mon();
    n_reset = 0; n_start = 0; n_resp = 0; n_overlap = 0; n_multi = 0;
    t_reset = -1; t_start0 = -1; t_resp = -1;
    d_start0 = '0; o_start0 = '0;
    for (int i = 0; i < NREQ; i++) n_ready[i] = 0;
    t_starts.delete();
    resp_q.delete();
    crc_q.delete();
  endtask

  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (gen.crc_reset) begin
      n_reset++;
      t_reset = cyc;
    end
    if (gen.crc_start) begin
      if (n_start == 0) begin
        t_start0 = cyc;
        d_start0 = gen.crc_data_in;
        o_start0 = gen.crc_orient;
      end
      t_starts.push_back(cyc);
      n_start++;
      if (gen.crc_reset) n_overlap++;
    end
    if ($countones(req_ready) > 1 || $countones(resp_valid) > 1) n_multi++;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) n_ready[i]++;
    if (resp_valid != '0) begin
      n_resp++;
      t_resp = cyc;
      resp_q.push_back(resp_valid);
      crc_q.push_back(resp_crc);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && active[i]) begin
        pos[i]++;
        if (pos[i] >= len[i]) active[i] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic set_msg(input int r, input int nw, input logic [31:0] w0,
                         input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] o);
    msg[r][0] = w0; msg[r][1] = w1; msg[r][2] = w2;
    len[r] = nw; pos[r] = 0; active[r] = 1'b1; hold[r] = 1'b0; orient_r[r] = o;
  endtask

  task automatic run_until(input int n, input int limit, input string name);
    int k;
    k = 0;
    while (n_resp < n && k < limit) begin
      tick();
      k++;
    end
    chk({name, " responses"}, 32'(n_resp), 32'(n));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " req_ready"},   32'(req_ready), 32'h0);
    chk({tag, " resp_valid"},  32'(resp_valid), 32'h0);
    chk({tag, " resp_crc"},    resp_crc, 32'h0);
    chk({tag, " crc_data_in"}, gen.crc_data_in, 32'h0);
    chk({tag, " crc_reset"},   32'(gen.crc_reset), 32'h0);
    chk({tag, " crc_start"},   32'(gen.crc_start), 32'h0);
    chk({tag, " crc_orient"},  gen.crc_orient, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, k, s0, r1;

    vt[0] = '{req:2, nw:1, w0:32'h12345678, w1:32'h0, w2:32'h0,
              orient:32'h04C11DB7, g:3, exp_crc:32'hDEADBEEF};
    vt[1] = '{req:0, nw:3, w0:32'h1, w1:32'h2, w2:32'h3,
              orient:32'h04C11DB7, g:0, exp_crc:32'hD61FA526};
    vt[2] = '{req:1, nw:2, w0:32'hFFFFFFFF, w1:32'h0, w2:32'h0,
              orient:32'h1EDC6F41, g:1, exp_crc:32'h14C3BB1C};
    vt[3] = '{req:3, nw:1, w0:32'hA5A5A5A5, w1:32'h0, w2:32'h0,
              orient:32'h0, g:0, exp_crc:32'h6DFD5085};

    for (int i = 0; i < NREQ; i++) begin
      active[i] = 1'b0; hold[i] = 1'b0; len[i] = 0; pos[i] = 0; orient_r[i] = '0;
      msg[i][0] = '0; msg[i][1] = '0; msg[i][2] = '0;
    end
    drive();
    clear_mon();
    repeat (3) tick();
    chk_outputs_zero("reset");
    #1 RST = 1'b0;
    tick(); tick();

    // single-message vectors
    for (int v = 0; v < 4; v++) begin
      g_busy = int'(vt[v].g);
      clear_mon();
      t0 = cyc;
      set_msg(int'(vt[v].req), int'(vt[v].nw), vt[v].w0, vt[v].w1, vt[v].w2, vt[v].orient);
      drive();
      run_until(1, 100, $sformatf("v%0d", v));
      repeat (3) tick();
      chk($sformatf("v%0d resp_count", v), 32'(n_resp), 32'd1);
      chk($sformatf("v%0d resp_valid", v), 32'(resp_q[0]), 32'(1 << vt[v].req));
      chk($sformatf("v%0d resp_crc", v), crc_q[0], vt[v].exp_crc);
      chk($sformatf("v%0d crc_orient", v), o_start0, vt[v].orient);
      chk($sformatf("v%0d first_data", v), d_start0, vt[v].w0);
      chk($sformatf("v%0d n_reset", v), 32'(n_reset), 32'd1);
      chk($sformatf("v%0d n_start", v), 32'(n_start), 32'(vt[v].nw));
      chk($sformatf("v%0d n_ready", v), 32'(n_ready[vt[v].req]), 32'(vt[v].nw));
      chk($sformatf("v%0d reset_lat", v), 32'(t_reset - t0), 32'd1);
      chk($sformatf("v%0d start_lat", v), 32'(t_start0 - t0), 32'd2);
      chk($sformatf("v%0d resp_lat", v), 32'(t_resp - t0), 32'(2 + vt[v].nw * (2 + vt[v].g)));
      if (vt[v].nw > 1)
        chk($sformatf("v%0d word_period", v), 32'(t_starts[1] - t_starts[0]), 32'(2 + vt[v].g));
      chk($sformatf("v%0d overlap", v), 32'(n_overlap), 32'd0);
      chk($sformatf("v%0d onehot", v), 32'(n_multi), 32'd0);
    end

    // all four requesters from reset, then 0 and 2 again
    #1 RST = 1'b1;
    tick(); tick();
    #1 RST = 1'b0;
    g_busy = 0;
    clear_mon();
    for (int i = 0; i < NREQ; i++) set_msg(i, 1, 32'h12345678, 32'h0, 32'h0, 32'h04C11DB7);
    drive();
    run_until(4, 200, "rr4");
    for (int i = 0; i < NREQ; i++) begin
      chk($sformatf("rr4 order%0d", i), 32'(resp_q[i]), 32'(1 << i));
      chk($sformatf("rr4 crc%0d", i), crc_q[i], 32'hDEADBEEF);
    end
    tick(); tick();
    clear_mon();
    set_msg(0, 1, 32'h12345678, 32'h0, 32'h0, 32'h04C11DB7);
    set_msg(2, 1, 32'h12345678, 32'h0, 32'h0, 32'h04C11DB7);
    drive();
    run_until(2, 100, "rr2");
    chk("rr2 first", 32'(resp_q[0]), 32'h1);
    chk("rr2 second", 32'(resp_q[1]), 32'h4);
    tick(); tick();

    // owner stalls mid-message while req 1 waits
    clear_mon();
    g_busy = 0;
    set_msg(0, 3, 32'h1, 32'h2, 32'h3, 32'h04C11DB7);
    set_msg(1, 1, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0);
    drive();
    k = 0;
    while (n_start < 1 && k < 50) begin
      tick();
      k++;
    end
    chk("stall first_start", 32'(n_start), 32'd1);
    chk("stall first_owner", 32'(n_ready[0]), 32'd1);
    hold[0] = 1'b1;
    drive();
    s0 = n_start;
    r1 = n_ready[1];
    repeat (5) tick();
    chk("stall no_start", 32'(n_start - s0), 32'd0);
    chk("stall no_grant_req1", 32'(n_ready[1] - r1), 32'd0);
    chk("stall no_resp", 32'(n_resp), 32'd0);
    hold[0] = 1'b0;
    drive();
    run_until(2, 200, "stall");
    chk("stall order0", 32'(resp_q[0]), 32'h1);
    chk("stall order1", 32'(resp_q[1]), 32'h2);
    chk("stall crc0", crc_q[0], 32'hD61FA526);
    chk("stall crc1", crc_q[1], 32'h6DFD5085);
    chk("stall n_start", 32'(n_start), 32'd4);
    tick(); tick();

    // reset asserted while waiting on the generator
    clear_mon();
    g_busy = 5;
    set_msg(1, 2, 32'h11111111, 32'h22222222, 32'h0, 32'h04C11DB7);
    drive();
    k = 0;
    while (n_start < 1 && k < 50) begin
      tick();
      k++;
    end
    chk("rstwait started", 32'(n_start), 32'd1);
    tick();
    #1 RST = 1'b1;
    #1;
    chk_outputs_zero("rstwait");
    for (int i = 0; i < NREQ; i++) active[i] = 1'b0;
    drive();
    tick(); tick();
    #1 RST = 1'b0;
    clear_mon();
    repeat (10) tick();
    chk("rstwait no_resp", 32'(n_resp), 32'd0);
    chk("rstwait no_start", 32'(n_start), 32'd0);
    g_busy = 2;
    set_msg(0, 1, 32'h12345678, 32'h0, 32'h0, 32'h04C11DB7);
    set_msg(3, 1, 32'h12345678, 32'h0, 32'h0, 32'h04C11DB7);
    drive();
    run_until(2, 200, "rstwait");
    chk("rstwait grant0", 32'(resp_q[0]), 32'h1);
    chk("rstwait grant3", 32'(resp_q[1]), 32'h8);
    chk("rstwait crc", crc_q[0], 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crc_scheduler.md
# crc_scheduler

Shares one polymorphic CRC generator among `NREQ` requesters on the APB side of the POLI block. It arbitrates whole messages round-robin and programs the generator's orientation (polynomial) for the winning requester. It then streams that requester's words into the generator one start/ready handshake at a time, and returns the final CRC to the owner with a one-cycle response strobe.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `WORD_SIZE`, 32: data/CRC width; taken from `POLI_types_pkg`.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  requester i has a word (or a pending message) on its bus.
- `req_data`  in  NREQ*WORD_SIZE  flattened words; requester i occupies slice [i*WORD_SIZE +: WORD_SIZE].
- `req_last`  in  NREQ  the current word is the final word of the message.
- `req_orient`  in  NREQ*WORD_SIZE  per-requester polynomial/orientation word.
- `req_ready`  out  NREQ  one-hot; the word from the owner is consumed this cycle.
- `resp_valid`  out  NREQ  one-hot, one-cycle pulse; the CRC for that requester's message is on `resp_crc`.
- `resp_crc`  out  WORD_SIZE  final CRC; valid only while `resp_valid` is nonzero.
- `crc_data_in`  out  WORD_SIZE  word to the generator.
- `crc_reset`  out  1  clears the generator accumulator.
- `crc_start`  out  1  one-cycle pulse; the generator consumes `crc_data_in`.
- `crc_orient`  out  WORD_SIZE  polynomial; held stable for the whole message.
- `crc_data_out`  in  WORD_SIZE  generator result.
- `crc_ready`  in  1  generator idle and `crc_data_out` valid.

## Operation
- States: IDLE, CLEAR, LOAD, WAIT, DONE. Reset state is IDLE.
- IDLE
  - When any `req_valid` is set, grant via round-robin starting at `rr_ptr` (the index after the last finished owner).
  - Latch `owner` and `crc_orient = req_orient[owner]`, then go to CLEAR.
- CLEAR
  - Assert `crc_reset` for exactly one cycle, then go to LOAD.
- LOAD
  - If `req_valid[owner]` is set: drive `crc_data_in = req_data[owner]`, `crc_start = 1`, `req_ready[owner] = 1` for one cycle, and latch `last = req_last[owner]`. Go to WAIT.
  - If `req_valid[owner]` is clear, stay in LOAD with ownership held. No preemption.
- WAIT
  - The first WAIT cycle ignores `crc_ready`, because the generator deasserts it the cycle after a start.
  - From the second WAIT cycle on, `crc_ready = 1` moves to DONE if `last` is set, otherwise to LOAD.
- DONE
  - Register `resp_crc = crc_data_out` and pulse `resp_valid[owner]` for one cycle.
  - Set `rr_ptr = (owner + 1) mod NREQ` and go to IDLE.
- Outputs are registered and default to 0 in every state not listed above. `crc_orient` and `resp_crc` hold their last value.
- Other requesters' `req_valid` are ignored while a message is owned; they stall without any drop.
- A one-word message (`req_last` set on the first word) is legal.

## Timing
- Reset values: all outputs 0, `rr_ptr = 0`, `owner = 0`, state IDLE. Reset mid-message abandons the message; no response is issued.
- Latency from `req_valid` rising in IDLE:
  - `crc_reset` in cycle +1.
  - First `crc_start`/`req_ready` in cycle +2.
- Each word costs 2 + G cycles, where G is the number of generator-busy cycles after the first WAIT cycle.
- `resp_valid` fires one cycle after the last word's `crc_ready` is seen.
- A new grant occurs no earlier than the cycle after DONE; IDLE lasts at least one cycle between messages.
- Requesters must hold `req_data`, `req_last` and `req_orient` stable while `req_valid` is set and `req_ready` is low.
- `crc_start` and `crc_reset` are never asserted in the same cycle.
- `crc_ready` asserted in the first WAIT cycle is ignored.

## Structure
- `POLI_types_pkg` gains:
  - `crc_sched_state_t`, a 3-bit enum of the states above.
  - `CRC_NREQ_MAX = 8`.
  - the `WORD_SIZE` reuse.
- One sub-module, `rr_arbiter`: combinational grant from the request vector and `rr_ptr`, producing a one-hot vector and an index.
- The scheduler drives the `crc_generator_if` signals by port, through the interface's generator-facing signals.

## Test plan
- Single request, one word: req 2 sends 0x12345678 with orient 0x04C11DB7; the generator model returns 0xDEADBEEF after 3 busy cycles.
  - Expect `crc_reset` at +1, `crc_start` at +2 with 0x12345678, `crc_orient` = 0x04C11DB7, and `resp_valid` = 4'b0100 with `resp_crc` = 0xDEADBEEF.
- Three-word message on req 0 (0x1, 0x2, 0x3 with last on 0x3): expect exactly 3 `crc_start` pulses and 1 `crc_reset` pulse, and `req_ready[0]` high exactly 3 cycles.
- All four requesters valid simultaneously from reset: expect grants in order 0, 1, 2, 3; after req 0 and req 2 re-request, expect order 0 then 2.
- Owner drops `req_valid` for 5 cycles mid-message while req 1 is valid: expect the state to stay in LOAD, no grant to req 1, and the message to complete after valid returns.
- Generator holds `crc_ready` = 1 continuously (zero busy cycles): expect no double `crc_start` and a 2-cycle word period.
- `RST` asserted in WAIT: expect all outputs 0 immediately, no `resp_valid`, and the next grant starting at req 0.
